// File: rtl/graphic_unit_scheduler_pkg.sv
// Shared types for the graphic unit scheduler: sequencer states, pixel/coordinate widths, RGB565 packing.
package graphic_unit_scheduler_pkg;

  localparam int COLOR_W = 16;
  localparam int COORD_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LAUNCH,
    ST_WAIT,
    ST_LINE_END,
    ST_WAIT_ACK
  } state_t;

  function automatic logic [COLOR_W-1:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                                input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/graphic_unit_scheduler_wr_mux.sv
// Forwards the selected unit's pixel write to the line buffer, clipped to LINE_W.
// Registered, 1-cycle latency; no backpressure, unselected or disabled writes are dropped.
module graphic_unit_scheduler_wr_mux
  import graphic_unit_scheduler_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int LINE_W  = 320,
  parameter int SEL_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [SEL_W-1:0]           sel,
  input  logic [N_UNITS-1:0]         unit_wr,
  input  logic [COORD_W*N_UNITS-1:0] unit_dx,
  input  logic [COLOR_W*N_UNITS-1:0] unit_data,
  output logic                       lb_wr,
  output logic [COORD_W-1:0]         lb_addr,
  output logic [COLOR_W-1:0]         lb_data
);

  logic               wr_sel;
  logic [COORD_W-1:0] dx_sel;
  logic [COLOR_W-1:0] data_sel;
  logic               wr_ok;

  always_comb begin
    wr_sel   = 1'b0;
    dx_sel   = '0;
    data_sel = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel == SEL_W'(i)) begin
        wr_sel   = unit_wr[i];
        dx_sel   = unit_dx[COORD_W*i +: COORD_W];
        data_sel = unit_data[COLOR_W*i +: COLOR_W];
      end
    end
  end

  assign wr_ok = en && wr_sel && (dx_sel < COORD_W'(LINE_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      lb_wr   <= 1'b0;
      lb_addr <= '0;
      lb_data <= '0;
    end else begin
      lb_wr <= wr_ok;
      if (wr_ok) begin
        lb_addr <= dx_sel;
        lb_data <= data_sel;
      end
    end
  end

endmodule

// File: rtl/graphic_unit_scheduler.sv
// Per-scanline sequencer: starts enabled units in index order, waits for done or watchdog, then
// handshakes the finished line with the display; the write path adds 1 cycle and never stalls units.
module graphic_unit_scheduler
  import graphic_unit_scheduler_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int LINES   = 240,
  parameter int LINE_W  = 320,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [N_UNITS-1:0]         unit_en,
  output logic [N_UNITS-1:0]         unit_start,
  input  logic [N_UNITS-1:0]         unit_done,
  input  logic [N_UNITS-1:0]         unit_wr,
  input  logic [COORD_W*N_UNITS-1:0] unit_dx,
  input  logic [COLOR_W*N_UNITS-1:0] unit_data,
  output logic [COORD_W-1:0]         dy,
  output logic                       lb_wr,
  output logic [COORD_W-1:0]         lb_addr,
  output logic [COLOR_W-1:0]         lb_data,
  output logic                       line_ready,
  input  logic                       line_ack,
  output logic                       busy,
  output logic                       frame_done,
  output logic [N_UNITS-1:0]         timeout_err
);

  // cur needs one extra bit to express "past the last unit"
  localparam int CUR_W = $clog2(N_UNITS) + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  state_t               state, state_n;
  logic [CUR_W-1:0]     cur, cur_n, pick;
  logic [COORD_W-1:0]   dy_n;
  logic [N_UNITS-1:0]   mask, mask_n, terr_n;
  logic [WD_W-1:0]      wd, wd_n;
  logic                 fdone_n, found, done_cur;

  always_comb begin
    found    = 1'b0;
    pick     = cur;
    done_cur = 1'b0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      if (mask[i] && (CUR_W'(i) >= cur)) begin
        found = 1'b1;
        pick  = CUR_W'(i);
      end
    end
    for (int i = 0; i < N_UNITS; i++) begin
      if (cur == CUR_W'(i)) done_cur = unit_done[i];
    end
  end

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    dy_n       = dy;
    mask_n     = mask;
    terr_n     = timeout_err;
    wd_n       = wd;
    fdone_n    = 1'b0;
    unit_start = '0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          mask_n  = unit_en;
          terr_n  = '0;
          dy_n    = '0;
          cur_n   = '0;
          state_n = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (found) begin
          cur_n   = pick;
          state_n = ST_LAUNCH;
        end else begin
          state_n = ST_LINE_END;
        end
      end
      ST_LAUNCH: begin
        for (int i = 0; i < N_UNITS; i++) unit_start[i] = (cur == CUR_W'(i));
        wd_n    = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_cur) begin
          cur_n   = cur + CUR_W'(1);
          state_n = ST_SELECT;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          for (int i = 0; i < N_UNITS; i++) begin
            if (cur == CUR_W'(i)) terr_n[i] = 1'b1;
          end
          cur_n   = cur + CUR_W'(1);
          state_n = ST_SELECT;
        end else if (wd != '1) begin
          wd_n = wd + WD_W'(1);
        end
      end
      ST_LINE_END: state_n = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (line_ack) begin
          if (dy == COORD_W'(LINES - 1)) begin
            fdone_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            dy_n    = dy + COORD_W'(1);
            cur_n   = '0;
            state_n = ST_SELECT;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      dy          <= '0;
      mask        <= '0;
      wd          <= '0;
      timeout_err <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      dy          <= dy_n;
      mask        <= mask_n;
      wd          <= wd_n;
      timeout_err <= terr_n;
      frame_done  <= fdone_n;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign line_ready = (state == ST_WAIT_ACK);

  graphic_unit_scheduler_wr_mux #(
    .N_UNITS(N_UNITS),
    .LINE_W (LINE_W),
    .SEL_W  (CUR_W)
  ) u_wr_mux (
    .clk      (clk),
    .reset    (reset),
    .en       (state == ST_WAIT),
    .sel      (cur),
    .unit_wr  (unit_wr),
    .unit_dx  (unit_dx),
    .unit_data(unit_data),
    .lb_wr    (lb_wr),
    .lb_addr  (lb_addr),
    .lb_data  (lb_data)
  );

endmodule

// File: tb/tb_graphic_unit_scheduler.sv
// Bench for graphic_unit_scheduler: behavioural unit models, write scoreboard, start-pulse log.
module tb_graphic_unit_scheduler;
  import graphic_unit_scheduler_pkg::*;

  localparam int N       = 4;
  localparam int LINES   = 4;
  localparam int LINE_W  = 320;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset, frame_start, line_ack;
  logic [N-1:0]    unit_en, unit_start, unit_done, unit_wr, timeout_err;
  logic [12*N-1:0] unit_dx;
  logic [16*N-1:0] unit_data;
  logic [11:0]     dy, lb_addr;
  logic [15:0]     lb_data;
  logic            lb_wr, line_ready, busy, frame_done;

  graphic_unit_scheduler #(.N_UNITS(N), .LINES(LINES), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .unit_en(unit_en),
    .unit_start(unit_start), .unit_done(unit_done), .unit_wr(unit_wr), .unit_dx(unit_dx),
    .unit_data(unit_data), .dy(dy), .lb_wr(lb_wr), .lb_addr(lb_addr), .lb_data(lb_data),
    .line_ready(line_ready), .line_ack(line_ack), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [11:0] addr; logic [15:0] data; int due;} wr_t;
  typedef struct {int unit; int line; int at;} st_t;
  typedef struct {logic [3:0] wr; logic [11:0] dx; logic [15:0] data; logic exp_wr;} vec_t;

  wr_t          sb[$];
  st_t          starts[$];
  vec_t         tbl[9];
  logic [N-1:0] terr_hist[4096];
  logic [N-1:0] prev_start;
  int           n_checks, n_fail, cyc, fd_n, fd_cyc, ack_cyc;
  int           cnt[N], delay[N];
  bit           wod[N];
  bit           auto_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_wr(input int u, input logic [11:0] dx, input logic [15:0] data);
    unit_wr[u]           = 1'b1;
    unit_dx[12*u +: 12]  = dx;
    unit_data[16*u +: 16] = data;
  endtask

  // One clock: sample outputs after the edge, run monitors and unit models, drive next inputs.
  task automatic tick();
    bit exp_wr;
    @(posedge clk);
    #1;
    cyc++;
    unit_wr     = '0;
    frame_start = 1'b0;
    line_ack    = 1'b0;
    exp_wr = (sb.size() > 0) && (sb[0].due == cyc);
    if (lb_wr || exp_wr) begin
      check("lb_wr", 32'(lb_wr), 32'(exp_wr));
      if (lb_wr && exp_wr) begin
        check("lb_addr", 32'(lb_addr), 32'(sb[0].addr));
        check("lb_data", 32'(lb_data), 32'(sb[0].data));
      end
      if (exp_wr) void'(sb.pop_front());
    end
    if (unit_start != '0) begin
      int u = 0;
      check("start_onehot", 32'($onehot(unit_start)), 32'd1);
      check("start_one_cycle", 32'(unit_start & prev_start), 32'd0);
      for (int i = 0; i < N; i++) if (unit_start[i]) u = i;
      starts.push_back('{u, int'(dy), cyc});
    end
    prev_start = unit_start;
    terr_hist[cyc % 4096] = timeout_err;
    if (frame_done) begin
      fd_n++;
      fd_cyc = cyc;
    end
    for (int i = 0; i < N; i++) begin
      unit_done[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          unit_done[i] = 1'b1;
          if (wod[i]) begin
            drive_wr(i, 12'(100 + i), 16'hA000 + 16'(i));
            sb.push_back('{12'(100 + i), 16'hA000 + 16'(i), cyc + 1});
          end
        end
      end
      if (unit_start[i] && delay[i] > 0) cnt[i] = delay[i];
    end
    if (auto_ack && line_ready) begin
      line_ack = 1'b1;
      ack_cyc  = cyc;
    end
  endtask

  task automatic wait_start(input int u, input int budget);
    int n = 0;
    while (!unit_start[u] && n < budget) begin
      tick();
      n++;
    end
    if (!unit_start[u]) check("wait_start_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_frame(input int budget);
    int n = 0;
    while (fd_n == 0 && n < budget) begin
      tick();
      n++;
    end
    check("frame_done_seen", 32'(fd_n), 32'd1);
  endtask

  task automatic start_frame(input logic [N-1:0] mask);
    starts.delete();
    fd_n        = 0;
    unit_en     = mask;
    frame_start = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, l2, d0, s0, n;
    tbl[0] = '{4'b0001, 12'd9,    16'h1111, 1'b0};
    tbl[1] = '{4'b0010, 12'd5,    16'hF800, 1'b0};
    tbl[2] = '{4'b0001, 12'd5,    rgb565(5'h1F, 6'h00, 5'h00), 1'b1};
    tbl[3] = '{4'b0001, 12'd319,  16'h07E0, 1'b1};
    tbl[4] = '{4'b0001, 12'd320,  16'h001F, 1'b0};
    tbl[5] = '{4'b0001, 12'd4095, 16'hFFFF, 1'b0};
    tbl[6] = '{4'b0001, 12'd0,    16'h1234, 1'b1};
    tbl[7] = '{4'b1000, 12'd10,   16'h5555, 1'b0};
    tbl[8] = '{4'b0101, 12'd7,    16'hABCD, 1'b1};
    n_checks = 0; n_fail = 0; cyc = 0; fd_n = 0; fd_cyc = 0; ack_cyc = 0;
    reset = 1'b1; frame_start = 1'b0; line_ack = 1'b0; unit_en = '0;
    unit_done = '0; unit_wr = '0; unit_dx = '0; unit_data = '0; prev_start = '0;
    auto_ack = 1'b0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; delay[i] = 10; wod[i] = 1'b0; end
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dy", 32'(dy), 32'd0);
    check("rst_start", 32'(unit_start), 32'd0);
    check("rst_line_ready", 32'(line_ready), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    tick();

    // Frame with mask 0101: u0,u2 per line, each retiring with a same-cycle write.
    wod[0] = 1'b1; wod[2] = 1'b1; auto_ack = 1'b1;
    start_frame(4'b0101);
    c0 = cyc;
    wait_frame(2000);
    check("seq_count", 32'(starts.size()), 32'(2 * LINES));
    for (int k = 0; k < starts.size(); k++) begin
      check("seq_unit", 32'(starts[k].unit), (k % 2 == 1) ? 32'd2 : 32'd0);
      check("seq_dy", 32'(starts[k].line), 32'(k / 2));
    end
    if (starts.size() >= 2) begin
      check("first_start_cycle", 32'(starts[0].at), 32'(c0 + 2));
      check("second_start_cycle", 32'(starts[1].at), 32'(starts[0].at + 12));
    end
    check("frame_done_after_ack", 32'(fd_cyc), 32'(ack_cyc + 1));
    tick();
    check("frame_done_pulse", 32'(fd_n), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    wod[0] = 1'b0; wod[2] = 1'b0;

    // Table of writes while unit 0 runs; entry 0 lands in the LAUNCH cycle.
    delay[0] = 12;
    start_frame(4'b0001);
    tick();
    wait_start(0, 50);
    foreach (tbl[k]) begin
      for (int i = 0; i < N; i++)
        if (tbl[k].wr[i]) drive_wr(i, tbl[k].dx, tbl[k].data ^ (16'h1111 * 16'(i)));
      if (tbl[k].exp_wr) sb.push_back('{tbl[k].dx, tbl[k].data, cyc + 1});
      tick();
    end
    wait_frame(2000);
    check("table_sb_empty", 32'(sb.size()), 32'd0);

    // Watchdog: unit 2 never finishes, unit 3 follows.
    delay[0] = 5; delay[1] = 5; delay[2] = 0; delay[3] = 5;
    start_frame(4'b1100);
    tick();
    wait_start(2, 50);
    l2 = cyc;
    wait_frame(3000);
    check("terr_before_limit", 32'(terr_hist[(l2 + 15) % 4096]), 32'd0);
    check("terr_after_limit", 32'(terr_hist[(l2 + 17) % 4096]), 32'b0100);
    if (starts.size() >= 2) check("after_timeout_unit", 32'(starts[1].unit), 32'd3);
    check("timeout_seq_count", 32'(starts.size()), 32'(2 * LINES));
    tick();
    check("terr_sticky", 32'(timeout_err), 32'b0100);

    // Empty mask clears flags and runs the frame without any start pulse.
    start_frame(4'b0000);
    tick();
    check("terr_cleared", 32'(timeout_err), 32'd0);
    wait_frame(200);
    check("empty_mask_starts", 32'(starts.size()), 32'd0);

    // Withheld ack, stray ack, frame_start while busy.
    auto_ack = 1'b0; delay[0] = 3;
    start_frame(4'b0001);
    tick();
    wait_start(0, 50);
    tick();
    line_ack = 1'b1;
    tick();
    unit_en = 4'b1111; frame_start = 1'b1;
    tick();
    n = 0;
    while (!line_ready && n < 100) begin tick(); n++; end
    check("line_ready_seen", 32'(line_ready), 32'd1);
    d0 = int'(dy);
    check("stray_ack_dy", 32'(d0), 32'd0);
    s0 = starts.size();
    for (int k = 0; k < 50; k++) begin
      drive_wr(0, 12'd3, 16'h0F0F);
      tick();
      if (k % 10 == 0) begin
        check("hold_line_ready", 32'(line_ready), 32'd1);
        check("hold_dy", 32'(dy), 32'(d0));
      end
    end
    check("hold_no_start", 32'(starts.size()), 32'(s0));
    line_ack = 1'b1;
    tick();
    check("ack_line_ready", 32'(line_ready), 32'd0);
    check("ack_dy", 32'(dy), 32'(d0 + 1));
    auto_ack = 1'b1;
    wait_frame(2000);
    check("busy_fs_count", 32'(starts.size()), 32'(LINES));
    for (int k = 0; k < starts.size(); k++) check("busy_fs_unit", 32'(starts[k].unit), 32'd0);

    // Reset in the middle of line 3.
    delay[0] = 10; delay[2] = 0;
    start_frame(4'b0101);
    tick();
    n = 0;
    while (!(unit_start[0] && dy == 12'd3) && n < 1000) begin tick(); n++; end
    check("reached_line3", 32'(dy), 32'd3);
    tick(); tick();
    drive_wr(0, 12'h055, 16'hBEEF);
    sb.push_back('{12'h055, 16'hBEEF, cyc + 1});
    tick();
    check("pre_reset_terr", 32'(timeout_err), 32'b0100);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dy", 32'(dy), 32'd0);
    check("mid_rst_start", 32'(unit_start), 32'd0);
    check("mid_rst_lb", {3'd0, lb_wr, lb_addr, lb_data}, 32'd0);
    check("mid_rst_terr", 32'(timeout_err), 32'd0);
    check("mid_rst_ready_done", 32'({line_ready, frame_done}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    s0 = starts.size();
    for (int k = 0; k < 5; k++) tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_no_start", 32'(starts.size()), 32'(s0));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
